poly2mono_arbiter: RTL

//  - Shares one poly2mono note-priority instance between NUM_SRC MIDI event sources (e.g. per-port parsers).
//  - Holds one pending note event per source and grants them round-robin.
//  - Sequences the downstream valid/ready protocol: one-cycle valid pulse, then wait for the downstream to finish.
//  - Sits between the MIDI parsers and poly2mono; all signals are on the one system clock.

---
 rtl/midi_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/poly2mono_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared types for the MIDI event path: note event record and arbiter states.
package midi_pkg;

  typedef struct packed {
    logic       note_on;
    logic [6:0] note_num;
    logic [6:0] velocity;
  } note_event_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } p2m_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                          req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  ptr,
  output logic [N-1:0]                          gnt_onehot,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  gnt_idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Scan the requests starting at ptr; the first hit wins.
  always_comb begin
    int  cand;
    logic found;
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      if (!found && req[cand]) begin
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = IW'(cand);
        found            = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/poly2mono_arbiter.sv
// Round-robin front end that funnels NUM_SRC MIDI note sources into a single
// poly2mono instance: one holding slot per source, one-cycle strobe per event,
// then waits for the downstream to go idle again (with a timeout).
module poly2mono_arbiter
  import midi_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NUM_SRC-1:0]                         src_valid,
  output logic [NUM_SRC-1:0]                         src_ready,
  input  logic [NUM_SRC-1:0]                         src_note_on,
  input  logic [NUM_SRC-1:0][6:0]                    src_note_num,
  input  logic [NUM_SRC-1:0][6:0]                    src_velocity,
  output logic                                       valid_out,
  output logic                                       note_on_out,
  output logic [6:0]                                 note_num_out,
  output logic [6:0]                                 velocity_out,
  input  logic                                       ready_in,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] grant_src,
  output logic                                       busy,
  output logic                                       timeout_err
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  p2m_arb_state_e     state, state_nx;
  logic [NUM_SRC-1:0] slot_full, slot_full_nx, accept;
  note_event_t        slot [NUM_SRC];
  logic [IW-1:0]      rr_ptr, rr_ptr_nx;
  logic [CW-1:0]      tmo_cnt, tmo_cnt_nx;
  logic [NUM_SRC-1:0] gnt_onehot;
  logic [IW-1:0]      gnt_idx;
  logic               grant_fire, tmo_hit;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req        (slot_full),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  // Next-state, timeout counting and slot occupancy.
  always_comb begin
    state_nx   = state;
    tmo_cnt_nx = tmo_cnt;
    grant_fire = 1'b0;
    tmo_hit    = 1'b0;
    accept     = src_valid & src_ready;
    case (state)
      IDLE: begin
        tmo_cnt_nx = '0;
        if (ready_in && (|slot_full)) begin
          grant_fire = 1'b1;
          state_nx   = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        tmo_cnt_nx = '0;
        state_nx   = GUARD;
      end
      GUARD: begin
        // Downstream lowers ready one cycle late, so ready_in is meaningless here.
        tmo_cnt_nx = tmo_cnt + CW'(1);
        state_nx   = WAIT;
      end
      WAIT: begin
        if (ready_in) begin
          tmo_cnt_nx = '0;
          state_nx   = IDLE;
        end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit    = 1'b1;
          tmo_cnt_nx = '0;
          state_nx   = IDLE;
        end else begin
          tmo_cnt_nx = tmo_cnt + CW'(1);
          state_nx   = WAIT;
        end
      end
      default: begin
        tmo_cnt_nx = '0;
        state_nx   = IDLE;
      end
    endcase
    slot_full_nx = (slot_full | accept) & ~(grant_fire ? gnt_onehot : {NUM_SRC{1'b0}});
    rr_ptr_nx    = (gnt_idx == IW'(NUM_SRC - 1)) ? '0 : (gnt_idx + IW'(1));
  end

  // Control state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      slot_full    <= '0;
      src_ready    <= {NUM_SRC{1'b1}};
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
      valid_out    <= 1'b0;
      note_on_out  <= 1'b0;
      note_num_out <= 7'd0;
      velocity_out <= 7'd0;
      grant_src    <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      slot_full   <= slot_full_nx;
      src_ready   <= ~slot_full_nx;
      tmo_cnt     <= tmo_cnt_nx;
      valid_out   <= (state_nx == ISSUE);
      busy        <= (state_nx != IDLE);
      timeout_err <= timeout_err | tmo_hit;
      if (grant_fire) begin
        rr_ptr       <= rr_ptr_nx;
        grant_src    <= gnt_idx;
        note_on_out  <= slot[gnt_idx].note_on;
        note_num_out <= slot[gnt_idx].note_num;
        velocity_out <= slot[gnt_idx].velocity;
      end
    end
  end

  // Per-source holding slots; fields are stored exactly as offered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          slot[i] <= '{note_on: src_note_on[i], note_num: src_note_num[i], velocity: src_velocity[i]};
        end
      end
    end
  end

endmodule
